// File: rtl/platform_rst_pkg.sv
// Shared types for the PL clock/reset sequencer: sequencer state encodings
// and a small elaboration-time helper.
package platform_rst_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WIZ_RST     = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    REL_IC      = 3'd3,
    RUN         = 3'd4
  } seq_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop bit synchronizer for bringing the wizard's locked flag into the
// sequencer clock domain; all stages clear to 0 on reset.
module rst_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
    end
  end

  assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/platform_rst_seq.sv
// PL clock/reset sequencer: resets the clocking wizard, qualifies lock, then
// releases interconnect and peripheral resets in order; handles lock loss and
// software-requested full resets.
module platform_rst_seq
  import platform_rst_pkg::*;
#(
  parameter int WIZ_RST_CYCLES      = 16,
  parameter int LOCK_SYNC_STAGES    = 2,
  parameter int LOCK_STABLE_CYCLES  = 32,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
  input  logic                   pl_clk0,
  input  logic                   pl_resetn,
  input  logic                   clk_wiz_locked,
  input  logic                   soft_rst_req,
  output logic                   clk_wiz_reset,
  output logic                   interconnect_aresetn,
  output logic                   peripheral_aresetn,
  output logic                   soft_rst_ack,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic [7:0]             lock_loss_cnt,
  output logic                   lock_timeout
);

  localparam int CNT_MAX = max_of(max_of(WIZ_RST_CYCLES, LOCK_STABLE_CYCLES),
                                  max_of(STAGE_GAP_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             armed_reg, armed_next;
  logic [7:0]       loss_reg, loss_next;
  logic             timeout_reg, timeout_next;
  logic             ack_next;
  logic             loss_event;
  logic             cnt_done;
  logic             locked_sync;
  logic             wiz_reg, ic_reg, per_reg, ack_reg;

  rst_seq_sync #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk   (pl_clk0),
    .rst_n (pl_resetn),
    .din   (clk_wiz_locked),
    .dout  (locked_sync)
  );

  // Dwell length of each state; the counter is loaded with this on entry.
  function automatic logic [CNT_W-1:0] load_for(input seq_state_t s);
    case (s)
      WIZ_RST:     return CNT_W'(WIZ_RST_CYCLES);
      WAIT_LOCK:   return CNT_W'(LOCK_TIMEOUT_CYCLES);
      LOCK_STABLE: return CNT_W'(LOCK_STABLE_CYCLES);
      REL_IC:      return CNT_W'(STAGE_GAP_CYCLES);
      default:     return '0;
    endcase
  endfunction

  assign cnt_done = (cnt_reg <= CNT_W'(1));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : cnt_reg;
    armed_next   = armed_reg;
    loss_next    = loss_reg;
    timeout_next = timeout_reg;
    ack_next     = 1'b0;
    loss_event   = 1'b0;

    case (state_reg)
      WIZ_RST: begin
        if (cnt_done) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_next = LOCK_STABLE;
        end else if (cnt_done) begin
          state_next   = WIZ_RST;
          timeout_next = 1'b1;
        end
      end
      LOCK_STABLE: begin
        if (!locked_sync)  state_next = WAIT_LOCK;
        else if (cnt_done) state_next = REL_IC;
      end
      REL_IC: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          loss_event = 1'b1;
        end else if (cnt_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        loss_event = !locked_sync;
        // A soft request overrides a simultaneous lock loss; the loss is still counted.
        if (soft_rst_req && armed_reg) begin
          state_next = WIZ_RST;
          ack_next   = 1'b1;
        end else if (!locked_sync) begin
          state_next = WAIT_LOCK;
        end
      end
      default: state_next = WIZ_RST;
    endcase

    if (state_next != state_reg) cnt_next = load_for(state_next);
    if (loss_event && loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;

    // Requester must drop the level once before it can be acknowledged again.
    if (!soft_rst_req) armed_next = 1'b1;
    if (ack_next)      armed_next = 1'b0;
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state_reg   <= WIZ_RST;
      cnt_reg     <= CNT_W'(WIZ_RST_CYCLES);
      armed_reg   <= 1'b1;
      loss_reg    <= 8'd0;
      timeout_reg <= 1'b0;
      wiz_reg     <= 1'b1;
      ic_reg      <= 1'b0;
      per_reg     <= 1'b0;
      ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      armed_reg   <= armed_next;
      loss_reg    <= loss_next;
      timeout_reg <= timeout_next;
      wiz_reg     <= (state_next == WIZ_RST);
      ic_reg      <= (state_next == REL_IC) || (state_next == RUN);
      per_reg     <= (state_next == RUN);
      ack_reg     <= ack_next;
    end
  end

  assign clk_wiz_reset        = wiz_reg;
  assign interconnect_aresetn = ic_reg;
  assign peripheral_aresetn   = per_reg;
  assign soft_rst_ack         = ack_reg;
  assign seq_state            = state_reg;
  assign lock_loss_cnt        = loss_reg;
  assign lock_timeout         = timeout_reg;

endmodule

// File: doc/platform_rst_seq.md
# platform_rst_seq

Clock-and-reset sequencer for the extensible platform PL region. Runs on the CIPS free-running `pl_clk0` and holds the clocking wizard in reset, waits for a stable `locked`, then releases the interconnect reset and the peripheral reset in order. It recovers from lock loss and services a software-requested full reset through a req/ack handshake. It replaces ad-hoc reset gating between CIPS, `clk_wizard_0` and the kernel interconnect.

## Interface
- `WIZ_RST_CYCLES`, 16: cycles `clk_wiz_reset` is held high on each wizard reset.
- `LOCK_SYNC_STAGES`, 2: flops in the `locked` synchronizer (min 2).
- `LOCK_STABLE_CYCLES`, 32: consecutive synchronized-locked cycles required before release.
- `STAGE_GAP_CYCLES`, 8: cycles between interconnect release and peripheral release.
- `LOCK_TIMEOUT_CYCLES`, 4096: maximum cycles in WAIT_LOCK before the wizard is re-reset.
- `pl_clk0` in 1: sequencer clock (CIPS pl_clk0).
- `pl_resetn` in 1: asynchronous active-low reset (CIPS pl0_resetn). Deassertion is synchronous to `pl_clk0`, so there is no internal reset synchronizer.
- `clk_wiz_locked` in 1: wizard `locked`, asynchronous to `pl_clk0`.
- `soft_rst_req` in 1: level request for a full platform reset.
- `clk_wiz_reset` out 1: active-high reset to the clocking wizard.
- `interconnect_aresetn` out 1: active-low interconnect reset.
- `peripheral_aresetn` out 1: active-low peripheral/kernel reset.
- `soft_rst_ack` out 1: one-cycle pulse when a soft reset is accepted.
- `seq_state` out 3: current state encoding.
- `lock_loss_cnt` out 8: saturating count of lock losses after release.
- `lock_timeout` out 1: sticky flag, set when a WAIT_LOCK timeout has occurred.

## Operation
- States and encodings: WIZ_RST=0, WAIT_LOCK=1, LOCK_STABLE=2, REL_IC=3, RUN=4. Codes 5–7 go to WIZ_RST.
- All outputs are registered Moore decodes of state:
  - `clk_wiz_reset` is 1 only in WIZ_RST.
  - `interconnect_aresetn` is 1 in REL_IC and RUN.
  - `peripheral_aresetn` is 1 only in RUN.
- One down-counter, sized to the largest parameter, is reloaded on every state entry.
- WIZ_RST: stays exactly `WIZ_RST_CYCLES` cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - `locked_sync`=1 → LOCK_STABLE.
  - After `LOCK_TIMEOUT_CYCLES` without lock → WIZ_RST and set `lock_timeout`.
- LOCK_STABLE:
  - `locked_sync`=0 → WAIT_LOCK (not counted as a loss).
  - `LOCK_STABLE_CYCLES` consecutive high cycles → REL_IC.
- REL_IC: after `STAGE_GAP_CYCLES` → RUN.
- Lock loss: `locked_sync`=0 in REL_IC or RUN → WAIT_LOCK on the next edge. Both aresetn outputs drop together, and `lock_loss_cnt` increments, saturating at 255.
- Soft reset:
  - `soft_rst_req` is sampled only in RUN. When sampled high: `soft_rst_ack`=1 for one cycle, and the next state is WIZ_RST.
  - A request outside RUN is not acked and is served on RUN entry if still high.
  - A new ack requires req to go low for ≥1 cycle after the previous ack.
- Simultaneous soft request and lock loss in RUN: the soft reset wins (WIZ_RST, ack pulsed), and `lock_loss_cnt` still increments.
- `lock_loss_cnt` and `lock_timeout` clear only on `pl_resetn`.

## Timing
- Reset values (`pl_resetn`=0, applied immediately):
  - state WIZ_RST, `clk_wiz_reset`=1, both aresetn=0, `soft_rst_ack`=0.
  - `lock_loss_cnt`=0, `lock_timeout`=0, counter loaded with `WIZ_RST_CYCLES`.
- Reset mid-operation: all outputs return to reset values asynchronously, and the sequence restarts from WIZ_RST.
- `clk_wiz_reset` falls after the `WIZ_RST_CYCLES`-th edge following reset deassertion.
- Release latency, measured from the edge that first samples `clk_wiz_locked`=1 (already in WAIT_LOCK):
  - `interconnect_aresetn` rises after `LOCK_SYNC_STAGES + LOCK_STABLE_CYCLES` edges (34 with defaults).
  - `peripheral_aresetn` rises `STAGE_GAP_CYCLES` later (42 with defaults).
- Lock-loss latency: aresetn falls `LOCK_SYNC_STAGES + 1` edges after the raw `locked` falls.
- `soft_rst_ack` is asserted in the same cycle the state leaves RUN.

## Structure
- `platform_rst_pkg` holds the state enum with its encodings and the `SEQ_STATE_W`=3 constant.
- Sub-module `rst_seq_sync` is a parameterized `LOCK_SYNC_STAGES`-deep bit synchronizer, reset to 0.
- Everything else lives in one FSM-plus-counter module.

## Test plan
- Power-up: release `pl_resetn` with `locked` rising 50 cycles later → `clk_wiz_reset` low after 16 edges; `interconnect_aresetn` high 34 edges after lock is sampled; `peripheral_aresetn` high 8 edges later; `seq_state`=4.
- Glitch: `locked` drops for 3 cycles at cycle 10 of LOCK_STABLE → return to WAIT_LOCK, `lock_loss_cnt` stays 0, the full 32-cycle qualification restarts.
- Lock loss in RUN: `locked` falls → both aresetn low 3 edges later, `lock_loss_cnt`=1; relock → normal re-release without pulsing `clk_wiz_reset`. Repeat 300 times → counter reads 255.
- Timeout: hold `locked`=0 → after 4096 cycles in WAIT_LOCK, `clk_wiz_reset` pulses for 16 cycles and `lock_timeout`=1 stays set.
- Soft reset: `soft_rst_req`=1 in RUN → a single one-cycle ack, full sequence replayed. Holding req high does not re-ack until req toggles low. Req plus lock loss on the same edge → ack, WIZ_RST, `lock_loss_cnt` increments.
- Async reset asserted during REL_IC → outputs return to reset values immediately, without waiting for a clock edge.
